// File: rtl/horizontal_tf_mul_row3_if.sv
// Stream bundle for the row-3 twiddle-factor multiplier: enable, mode select,
// sample/twiddle input, result output with group framing and range-error flag.
interface horizontal_tf_mul_row3_if #(
  parameter int unsigned P_WIDTH  = 64,
  parameter int unsigned SC_WIDTH = 3
);
  logic                CEN;
  logic [SC_WIDTH-1:0] stage_counter;
  logic                in_valid;
  logic [P_WIDTH-1:0]  data_in;
  logic [P_WIDTH-1:0]  tf_in;
  logic                out_valid;
  logic [P_WIDTH-1:0]  data_out;
  logic                out_last;
  logic                err;

  modport master (
    output CEN, stage_counter, in_valid, data_in, tf_in,
    input  out_valid, data_out, out_last, err
  );

  modport slave (
    input  CEN, stage_counter, in_valid, data_in, tf_in,
    output out_valid, data_out, out_last, err
  );
endinterface

// File: rtl/horizontal_tf_mul_row3.sv
// Row-3 horizontal twiddle-factor multiplier: (data * tf) mod p with
// p = 2^64 - 2^32 + 1, three register stages, bypass when stage_counter != 0,
// 16-sample group framing on out_last.
// Optional macro TF_MUL_RANGE_CHECK_EN adds a sticky err flag for inputs >= p.
module horizontal_tf_mul_row3 #(
  parameter int unsigned P_WIDTH      = 64,
  parameter int unsigned SC_WIDTH     = 3,
  parameter int unsigned GRP_LEN_LOG2 = 4
) (
  input logic                     clk,
  input logic                     rst_n,  // active-high asynchronous reset
  horizontal_tf_mul_row3_if.slave bus
);

  localparam logic [P_WIDTH-1:0] Prime = 64'hFFFF_FFFF_0000_0001;
  localparam logic [P_WIDTH-1:0] Eps   = 64'h0000_0000_FFFF_FFFF;  // 2^64 mod p

  logic                    en;
  assign en = ~bus.CEN;

  // S1 registers
  logic [2*P_WIDTH-1:0]    prod_q;
  logic                    mode1_q;
  logic [P_WIDTH-1:0]      raw1_q;
  logic                    v1_q;

  // S2 registers
  logic [P_WIDTH-1:0]      t0_q;
  logic [P_WIDTH-1:0]      t1_q;
  logic                    mode2_q;
  logic [P_WIDTH-1:0]      raw2_q;
  logic                    v2_q;

  // S3 / output registers
  logic [P_WIDTH-1:0]      data_out_q;
  logic                    out_valid_q;
  logic                    out_last_q;
  logic [GRP_LEN_LOG2-1:0] cnt_q;

  logic [P_WIDTH-1:0]      t0_d;
  logic [P_WIDTH-1:0]      t1_d;
  logic [P_WIDTH-1:0]      res_d;

  // S2 folding: x = lo + b*2^64 + a*2^96 == lo - a + b*(2^32 - 1) (mod p)
  always_comb begin
    logic [P_WIDTH-1:0] lo;
    logic [P_WIDTH-1:0] a;
    logic [P_WIDTH-1:0] b;
    logic [P_WIDTH:0]   diff;
    lo   = prod_q[P_WIDTH-1:0];
    a    = {32'h0, prod_q[127:96]};
    b    = {32'h0, prod_q[95:64]};
    diff = {1'b0, lo} - {1'b0, a};
    // A borrow means the wrapped value is 2^64 too large; 2^64 == Eps
    t0_d = diff[P_WIDTH] ? (diff[P_WIDTH-1:0] - Eps) : diff[P_WIDTH-1:0];
    t1_d = (b << 32) - b;
  end

  // S3 final add, carry fold and canonical reduction, or bypass of raw data
  always_comb begin
    logic [P_WIDTH:0]   sum;
    logic [P_WIDTH-1:0] r;
    sum = {1'b0, t0_q} + {1'b0, t1_q};
    r   = sum[P_WIDTH] ? (sum[P_WIDTH-1:0] + Eps) : sum[P_WIDTH-1:0];
    if (r >= Prime) begin
      r = r - Prime;
    end
    res_d = mode2_q ? r : raw2_q;
  end

  // Pipeline and group counter; everything freezes while CEN is high
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      prod_q      <= '0;
      mode1_q     <= 1'b0;
      raw1_q      <= '0;
      v1_q        <= 1'b0;
      t0_q        <= '0;
      t1_q        <= '0;
      mode2_q     <= 1'b0;
      raw2_q      <= '0;
      v2_q        <= 1'b0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      cnt_q       <= '0;
    end else if (en) begin
      prod_q      <= bus.data_in * bus.tf_in;
      mode1_q     <= (bus.stage_counter == '0);
      raw1_q      <= bus.data_in;
      v1_q        <= bus.in_valid;
      t0_q        <= t0_d;
      t1_q        <= t1_d;
      mode2_q     <= mode1_q;
      raw2_q      <= raw1_q;
      v2_q        <= v1_q;
      data_out_q  <= res_d;
      out_valid_q <= v2_q;
      out_last_q  <= v2_q & (cnt_q == '1);
      if (v2_q) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;

`ifdef TF_MUL_RANGE_CHECK_EN
  logic err_q;

  // Sticky flag for any non-canonical operand seen at S1 capture
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      err_q <= 1'b0;
    end else if (en && bus.in_valid && ((bus.data_in >= Prime) || (bus.tf_in >= Prime))) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_horizontal_tf_mul_row3.sv
// Scoreboard bench for horizontal_tf_mul_row3: directed vectors push expected
// results; a negedge monitor pops and compares data, framing and latency.
module tb_horizontal_tf_mul_row3;

  localparam logic [63:0] PM1 = 64'hFFFF_FFFF_0000_0000;

  typedef struct packed {
    logic [63:0] d;
    logic        last;
    logic [31:0] stamp;
  } exp_t;

  logic        clk;
  logic        rst_n;
  exp_t        sb[$];
  int          n_tests;
  int          n_fail;
  int          grp_cnt;
  logic [31:0] en_edges;
  logic        last_en;
  logic [63:0] held_d;
  logic        held_v;

  horizontal_tf_mul_row3_if bus ();

  horizontal_tf_mul_row3 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    last_en <= ~bus.CEN;
    if (!bus.CEN) en_edges <= en_edges + 1;
  end

  // Monitor: compare on every enabled edge with a valid output, check hold otherwise
  always @(negedge clk) begin
    if (rst_n) begin
      held_d = '0;
      held_v = 1'b0;
    end else begin
      if (last_en) begin
        if (bus.out_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_output", {63'h0, bus.out_valid}, 64'h0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("data_out", bus.data_out, e.d);
            check("out_last", {63'h0, bus.out_last}, {63'h0, e.last});
            check("latency", {32'h0, en_edges}, {32'h0, e.stamp});
          end
        end else if (bus.out_last) begin
          check("last_without_valid", {63'h0, bus.out_last}, 64'h0);
        end
      end else begin
        check("freeze_data", bus.data_out, held_d);
        check("freeze_valid", {63'h0, bus.out_valid}, {63'h0, held_v});
      end
      held_d = bus.data_out;
      held_v = bus.out_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] sc, input logic [63:0] d, input logic [63:0] t,
                      input logic [63:0] exp, input bit push);
    exp_t e;
    bus.CEN           = 1'b0;
    bus.stage_counter = sc;
    bus.in_valid      = 1'b1;
    bus.data_in       = d;
    bus.tf_in         = t;
    if (push) begin
      e.d     = exp;
      e.last  = (grp_cnt % 16 == 15);
      e.stamp = en_edges + 3;
      sb.push_back(e);
      grp_cnt++;
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic bubble();
    bus.CEN      = 1'b0;
    bus.in_valid = 1'b0;
    bus.data_in  = 64'h5555_AAAA_5555_AAAA;
    bus.tf_in    = 64'h1;
    step();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      bubble();
      k++;
    end
    check("drain_empty", 64'(sb.size()), 64'h0);
  endtask

  initial begin
    n_tests           = 0;
    n_fail            = 0;
    grp_cnt           = 0;
    en_edges          = 0;
    last_en           = 1'b0;
    rst_n             = 1'b1;
    bus.CEN           = 1'b1;
    bus.stage_counter = '0;
    bus.in_valid      = 1'b0;
    bus.data_in       = '0;
    bus.tf_in         = '0;
    step();
    step();
    check("rst_data_out", bus.data_out, 64'h0);
    check("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    check("rst_out_last", {63'h0, bus.out_last}, 64'h0);
    check("rst_err", {63'h0, bus.err}, 64'h0);
    rst_n = 1'b0;
    bubble();
    bubble();

    // Multiply vectors, then bypass, then back to multiply
    send(3'd0, 64'd2, 64'd3, 64'd6, 1);
    send(3'd0, 64'h1_0000_0000, 64'h1_0000_0000, 64'h0000_0000_FFFF_FFFF, 1);
    send(3'd0, PM1, PM1, 64'h1, 1);
    send(3'd0, PM1, 64'd2, 64'hFFFF_FFFE_FFFF_FFFF, 1);
    send(3'd0, 64'h1_0000_0000, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_8000_0000, 1);
    send(3'd1, 64'h1234, 64'hDEAD_BEEF, 64'h1234, 1);
    send(3'd5, 64'hFEDC_BA98_7654_3210, 64'h7, 64'hFEDC_BA98_7654_3210, 1);
    send(3'd0, 64'd7, 64'd9, 64'd63, 1);

    // Freeze mid-stream with garbage on the inputs
    send(3'd0, 64'd11, 64'd13, 64'd143, 1);
    send(3'd0, 64'd100, 64'd100, 64'd10000, 1);
    for (int i = 0; i < 5; i++) begin
      bus.CEN      = 1'b1;
      bus.in_valid = 1'b1;
      bus.data_in  = 64'hBAD;
      bus.tf_in    = 64'hBAD;
      step();
    end
    send(3'd2, 64'h77, 64'h99, 64'h77, 1);
    send(3'd0, 64'd5, 64'd5, 64'd25, 1);
    drain();
    check("err_clean_inputs", {63'h0, bus.err}, 64'h0);

    // Reset with three samples in flight
    send(3'd0, 64'd1, 64'd1, 64'd0, 0);
    send(3'd0, 64'd2, 64'd2, 64'd0, 0);
    send(3'd0, 64'd3, 64'd3, 64'd0, 0);
    rst_n = 1'b1;
    #1;
    check("midrst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    check("midrst_data_out", bus.data_out, 64'h0);
    check("midrst_out_last", {63'h0, bus.out_last}, 64'h0);
    sb.delete();
    grp_cnt = 0;
    step();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) bubble();

    // Framing: 40 back-to-back, then 20 more with two bubbles
    for (int i = 0; i < 40; i++) begin
      send(3'd0, 64'(i + 1), 64'd3, 64'(3 * (i + 1)), 1);
    end
    for (int i = 0; i < 20; i++) begin
      if (i == 4 || i == 9) bubble();
      send(3'd1, 64'(1000 + i), 64'd0, 64'(1000 + i), 1);
    end
    drain();

    // Out-of-range twiddle
    send(3'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFE, 1);
`ifdef TF_MUL_RANGE_CHECK_EN
    check("err_set", {63'h0, bus.err}, 64'h1);
`else
    check("err_tied", {63'h0, bus.err}, 64'h0);
`endif
    drain();
    for (int i = 0; i < 3; i++) bubble();
`ifdef TF_MUL_RANGE_CHECK_EN
    check("err_sticky", {63'h0, bus.err}, 64'h1);
`else
    check("err_still_tied", {63'h0, bus.err}, 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/horizontal_tf_mul_row3.md
Name: horizontal_tf_mul_row3

Overview:
- Consumer side of the row-3 horizontal twiddle-factor stream: takes one butterfly output sample per cycle and the 64-bit twiddle factor presented with it, and returns (data × tf) mod p.
- p = 2^64 − 2^32 + 1 (Goldilocks prime).
- Sits between the row-3 radix-16 butterfly and the next-stage memory write-back of the 16384-point NTT.
- Fully pipelined: 3-cycle latency, one result per enabled cycle, 16-sample group framing on the output.

Parameters:
- P_WIDTH, 64, data and twiddle width; only 64 is supported.
- SC_WIDTH, 3, stage_counter width.
- GRP_LEN_LOG2, 4, log2 of samples per twiddle group (16).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-high.
- CEN  input  1  active-low enable; CEN=1 freezes the whole pipeline.
- stage_counter  input  SC_WIDTH  NTT stage; multiply only when 0, otherwise bypass.
- in_valid  input  1  data_in/tf_in valid this cycle.
- data_in  input  P_WIDTH  butterfly output sample, canonical (< p).
- tf_in  input  P_WIDTH  twiddle factor aligned with data_in.
- out_valid  output  1  data_out valid.
- data_out  output  P_WIDTH  canonical result (< p).
- out_last  output  1  high with the 16th valid output of each group.
- err  output  1  sticky range error (see Optional Feature).

Behaviour:
- Reset (rst_n=1, asynchronous):
  - data_out=0, out_valid=0, out_last=0, err=0.
  - Group counter=0; all pipeline valid bits=0.
  - Reset mid-operation discards all in-flight samples.
- Enable gating:
  - All state advances only when CEN=0.
  - When CEN=1, every pipeline register, valid bit and counter holds, and the outputs hold their values.
- Pipeline, each stage advanced when CEN=0:
  - S1: register the 128-bit product x = data_in*tf_in, the stage_counter==0 flag as mode, the raw data_in, and in_valid.
  - S2: split x into lo=x[63:0], a=x[127:96], b=x[95:64]. Compute t0=lo−a; on borrow, t0=t0−(2^32−1) mod 2^64. Register t0 and t1=(b<<32)−b.
  - S3: r=t0+t1; on carry, r=r+(2^32−1). If r≥p, r=r−p. Register r as data_out and the valid bit as out_valid.
- Latency: a sample accepted at enabled edge n appears at enabled edge n+3.
- Bypass: when mode=0 (stage_counter≠0), data_out = raw data_in with the same 3-cycle latency; tf_in is ignored.
- Bubbles: in_valid=0 inserts a bubble (out_valid=0 three enabled cycles later). data_out may change on bubbles and is don't-care while out_valid=0.
- Group counter:
  - 4-bit counter increments on each enabled cycle where S3 output valid is 1.
  - out_last = valid & (counter==15), registered alongside data_out.
  - Counter wraps 15→0.
  - Bypass samples are counted too.
- stage_counter may change on any cycle; each sample uses the mode captured at S1.

Optional Feature:
- Macro: TF_MUL_RANGE_CHECK_EN.
- Defined: at S1 capture, if in_valid=1 and (data_in≥p or tf_in≥p), err is set to 1 and stays set until reset. The sample is still processed and the result is still reduced < p.
- Not defined: no comparators; err is tied to 0.

Test Plan:
- Multiply: stage_counter=0, data_in=2, tf_in=3, in_valid=1 → three enabled cycles later data_out=6, out_valid=1.
- Wrap into 2^64: data_in=tf_in=0x0000000100000000 → data_out=0x00000000FFFFFFFF. Also data_in=tf_in=p−1 (0xFFFFFFFF00000000) → data_out=1.
- Bypass and stall:
  - stage_counter=1, data_in=0x1234, tf_in=0xDEADBEEF → data_out=0x1234 after 3 cycles.
  - Raise CEN for 5 cycles mid-stream → outputs frozen, resume with no sample lost or duplicated.
- Framing: 40 back-to-back valid samples → out_last high on outputs 16 and 32 only. Inject 2 bubbles → out_last still on the 16th valid sample.
- Reset mid-stream: assert rst_n with 3 samples in flight → out_valid=0 and data_out=0 immediately. After release, no stale output appears and the counter restarts at 0.
- With TF_MUL_RANGE_CHECK_EN: tf_in=0xFFFFFFFFFFFFFFFF → err=1 the cycle after capture and stays 1. Without the macro, err stays 0.
